// File: rtl/clock_pkg.sv
// Shared time-of-day definitions: set-mode encoding and BCD field limits.
// Also used by the display and seven-segment decoder blocks.
package clock_pkg;

   typedef enum logic [1:0] {
      MODE_RUN     = 2'b00,
      MODE_SET_HR  = 2'b01,
      MODE_SET_MIN = 2'b10
   } mode_t;

   localparam logic [7:0] BCD_MAX_SEC = 8'h59;
   localparam logic [7:0] BCD_MAX_MIN = 8'h59;
   localparam logic [7:0] BCD_MAX_HR  = 8'h23;
   localparam logic [7:0] BCD_NOON    = 8'h12;

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit packed-BCD counter that wraps from MAX to 8'h00 with a carry.
// A clear has priority over an increment. Any illegal or out-of-range value reloads 8'h00.
module bcd_mod_counter #(
   parameter logic [7:0] MAX = 8'h59
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       inc,
   input  logic       clr,
   output logic [7:0] value,
   output logic       carry
);

   logic [7:0] r_val;
   logic [7:0] w_nxt;
   logic       w_legal;
   logic       w_at_max;

   assign w_legal  = (r_val[3:0] <= 4'd9) && (r_val[7:4] <= 4'd9) && (r_val <= MAX);
   assign w_at_max = (r_val == MAX);
   assign carry    = inc && !clr && w_at_max;
   assign value    = r_val;

   always_comb begin
      w_nxt = 8'h00;
      if (w_legal && !w_at_max) begin
         if (r_val[3:0] == 4'd9)
            w_nxt = {r_val[7:4] + 4'd1, 4'd0};
         else
            w_nxt = {r_val[7:4], r_val[3:0] + 4'd1};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_val <= 8'h00;
      else if (clr)
         r_val <= 8'h00;
      else if (inc)
         r_val <= w_nxt;
   end

endmodule

// File: rtl/bcd_time_counter.sv
// Time-of-day core: 1 Hz prescaler, RUN/SET_HR/SET_MIN mode FSM and BCD hh:mm:ss chain.
// Time and sec_tick update one edge after the prescaler wrap; ALARM_EN adds alarm_set/alarm_hit.
module bcd_time_counter
   import clock_pkg::*;
#(
   parameter int CLK_HZ   = 100_000_000,
   parameter int TICK_DIV = CLK_HZ
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   input  logic       mode_btn,
   input  logic       inc_btn,
`ifdef ALARM_EN
   input  logic       alarm_set,
   output logic       alarm_hit,
`endif
   output logic [7:0] hours_bcd,
   output logic [7:0] minutes_bcd,
   output logic [7:0] seconds_bcd,
   output logic       pm,
   output logic [1:0] mode,
   output logic       sec_tick
);

   localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

   mode_t              r_mode, w_mode_nxt;
   logic [PRESC_W-1:0] r_presc;
   logic               r_sec_tick;
   logic               w_counting, w_tick, w_inc_ok;
   logic               w_sec_clr, w_min_inc, w_hr_inc;
   logic               w_sec_carry, w_min_carry, w_hr_carry;
   logic [7:0]         w_sec, w_min, w_hr;

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_mode <= MODE_RUN;
      else
         r_mode <= w_mode_nxt;
   end

   always_comb begin
      w_mode_nxt = r_mode;
      if (mode_btn) begin
         case (r_mode)
            MODE_RUN:     w_mode_nxt = MODE_SET_HR;
            MODE_SET_HR:  w_mode_nxt = MODE_SET_MIN;
            default:      w_mode_nxt = MODE_RUN;
         endcase
      end
   end

   // A mode press always changes mode, so it also resets the prescaler and suppresses the tick.
   assign w_counting = (r_mode == MODE_RUN) && run;
   assign w_tick     = w_counting && (r_presc == PRESC_LAST) && !mode_btn;
   assign w_inc_ok   = inc_btn && !mode_btn;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_presc    <= '0;
         r_sec_tick <= 1'b0;
      end else begin
         r_sec_tick <= w_tick;
         if (mode_btn || (w_counting && r_presc == PRESC_LAST))
            r_presc <= '0;
         else if (w_counting)
            r_presc <= r_presc + 1'b1;
      end
   end

   assign w_sec_clr = mode_btn && (r_mode == MODE_RUN);
   assign w_min_inc = (w_tick && w_sec_carry) || ((r_mode == MODE_SET_MIN) && w_inc_ok);
   assign w_hr_inc  = ((r_mode == MODE_RUN) && w_min_carry) || ((r_mode == MODE_SET_HR) && w_inc_ok);

   bcd_mod_counter #(.MAX(BCD_MAX_SEC)) u_sec (
      .clk(clk), .rst_n(rst_n), .inc(w_tick), .clr(w_sec_clr), .value(w_sec), .carry(w_sec_carry)
   );

   bcd_mod_counter #(.MAX(BCD_MAX_MIN)) u_min (
      .clk(clk), .rst_n(rst_n), .inc(w_min_inc), .clr(1'b0), .value(w_min), .carry(w_min_carry)
   );

   bcd_mod_counter #(.MAX(BCD_MAX_HR)) u_hr (
      .clk(clk), .rst_n(rst_n), .inc(w_hr_inc), .clr(1'b0), .value(w_hr), .carry(w_hr_carry)
   );

`ifdef ALARM_EN
   logic [15:0] r_alarm;
   logic        r_alarm_hit;

   // Matches one cycle after the tick that lands on HH:MM:00.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_alarm     <= 16'h0000;
         r_alarm_hit <= 1'b0;
      end else begin
         if (alarm_set)
            r_alarm <= {w_hr, w_min};
         r_alarm_hit <= r_sec_tick && (r_mode == MODE_RUN) && (w_sec == 8'h00)
                        && ({w_hr, w_min} == r_alarm);
      end
   end

   assign alarm_hit = r_alarm_hit;
`endif

   assign hours_bcd   = w_hr;
   assign minutes_bcd = w_min;
   assign seconds_bcd = w_sec;
   assign pm          = (w_hr >= BCD_NOON);
   assign mode        = r_mode;
   assign sec_tick    = r_sec_tick;

   logic w_unused;
   assign w_unused = w_hr_carry;

endmodule
